// File: rtl/gpio_reg_pkg.sv
// Register-interface types shared between the GPIO register block and its hardware side.
package gpio_reg_pkg;

  localparam int GpioMaxPins = 32;

  localparam logic [7:0] GPIO_EN_OFFSET          = 8'h00;
  localparam logic [7:0] GPIO_DIR_OFFSET         = 8'h04;
  localparam logic [7:0] GPIO_OUT_OFFSET         = 8'h08;
  localparam logic [7:0] GPIO_TOGGLE_OFFSET      = 8'h0C;
  localparam logic [7:0] GPIO_IN_OFFSET          = 8'h10;
  localparam logic [7:0] GPIO_INTRPT_EN_OFFSET   = 8'h14;
  localparam logic [7:0] GPIO_INTRPT_EDGE_OFFSET = 8'h18;
  localparam logic [7:0] GPIO_INTRPT_OFFSET      = 8'h1C;

  typedef struct packed {
    logic en;
    logic dir;
    logic out;
    logic toggle;
    logic intrpt_en;
    logic intrpt_edge;
    logic intrpt;
  } gpio_reg2hw_t;

  typedef struct packed {
    logic sync_in;
    logic intrpt;
    logic intrpt_valid;
    logic out;
    logic out_valid;
  } gpio_hw2reg_t;

endpackage

// File: rtl/gpio_pin_slice.sv
// One pin: pad drive, input synchroniser, edge/interrupt detection and toggle servicing.
module gpio_pin_slice
  import gpio_reg_pkg::*;
#(
  parameter int SyncStages = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  gpio_reg2hw_t reg2hw_i,
  input  logic         gpio_in_i,
  input  logic         hit_mask_i,
  output gpio_hw2reg_t hw2reg_o,
  output logic         gpio_out_o,
  output logic         gpio_oe_o,
  output logic         irq_set_o
);

  logic [SyncStages-1:0] sync_q, sync_d;
  logic                  prev_q;
  logic                  sync, rise, fall, hit;

  assign sync_d = {sync_q[SyncStages-2:0], gpio_in_i};

  // prev_q tracks the synchroniser regardless of en/dir so config changes never fake an edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= sync_q[SyncStages-1];
    end
  end

  always_comb begin
    sync = sync_q[SyncStages-1];
    rise = sync & ~prev_q;
    fall = ~sync & prev_q;
    hit  = ~hit_mask_i & reg2hw_i.en & ~reg2hw_i.dir & reg2hw_i.intrpt_en &
           (reg2hw_i.intrpt_edge ? rise : fall);

    hw2reg_o              = '0;
    hw2reg_o.sync_in      = reg2hw_i.en & sync;
    hw2reg_o.intrpt       = hit;
    hw2reg_o.intrpt_valid = hit;
    hw2reg_o.out          = reg2hw_i.toggle ? ~reg2hw_i.out : reg2hw_i.out;
    hw2reg_o.out_valid    = reg2hw_i.toggle;
  end

  assign gpio_oe_o  = reg2hw_i.en & reg2hw_i.dir;
  assign gpio_out_o = reg2hw_i.en & reg2hw_i.dir & reg2hw_i.out;
  assign irq_set_o  = reg2hw_i.intrpt & reg2hw_i.intrpt_en;

endmodule

// File: rtl/gpio_pin_ctrl.sv
// Hardware side of the GPIO register file: per-pin slices, post-reset settle guard and
// registered interrupt lines.
module gpio_pin_ctrl
  import gpio_reg_pkg::*;
#(
  parameter int NumGpios   = 32,
  parameter int SyncStages = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  gpio_reg2hw_t [NumGpios-1:0]  reg2hw_i,
  output gpio_hw2reg_t [NumGpios-1:0]  hw2reg_o,
  input  logic         [NumGpios-1:0]  gpio_in_i,
  output logic         [NumGpios-1:0]  gpio_out_o,
  output logic         [NumGpios-1:0]  gpio_oe_o,
  output logic         [NumGpios-1:0]  gpio_irq_o,
  output logic                         irq_o
);

  localparam int              CntW       = $clog2(SyncStages + 2);
  localparam logic [CntW-1:0] SettleLoad = CntW'(SyncStages + 1);

  logic [CntW-1:0]     settle_q, settle_d;
  logic [NumGpios-1:0] irq_d, gpio_irq_q;
  logic                irq_q;
  logic                hit_mask;

  // Edges are masked until the synchronisers and prev_q have refilled after reset.
  assign hit_mask = (settle_q != '0);
  assign settle_d = hit_mask ? settle_q - CntW'(1) : '0;

  for (genvar i = 0; i < NumGpios; i++) begin : g_pin
    gpio_pin_slice #(
      .SyncStages(SyncStages)
    ) u_slice (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .reg2hw_i   (reg2hw_i[i]),
      .gpio_in_i  (gpio_in_i[i]),
      .hit_mask_i (hit_mask),
      .hw2reg_o   (hw2reg_o[i]),
      .gpio_out_o (gpio_out_o[i]),
      .gpio_oe_o  (gpio_oe_o[i]),
      .irq_set_o  (irq_d[i])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      settle_q   <= SettleLoad;
      gpio_irq_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      settle_q   <= settle_d;
      gpio_irq_q <= irq_d;
      irq_q      <= |irq_d;
    end
  end

  assign gpio_irq_o = gpio_irq_q;
  assign irq_o      = irq_q;

endmodule
